cond_issue_queue: RTL and testbench

Clocked, parametrised successor to the asynchronous condition-code issuer. It sits between fetch and decode and buffers fetched instruction words in a DEPTH-entry FIFO. It evaluates the ARM condition field of the head entry against the CPSR flags. Passing instructions go to decode over a valid/ready handshake; failing ones are squashed and counted. It adds an explicit flag interlock, a pipeline flush, correct LS/NV handling and a bypass mode.

---
 rtl/cond_issue_queue.sv | 112 +++++++++++
 tb/tb_cond_issue_queue.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/cond_issue_queue.sv
// rtl/cond_issue_queue.sv - instruction FIFO with ARM condition evaluation, squash counting and issue register
module cond_issue_queue #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic [31:0]       cpsr,
    input  logic              flags_busy,
    input  logic              flush,
    input  logic              cond_bypass,
    output logic [CNT_W-1:0]  squash_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count;

    logic [DATA_W-1:0] head;
    logic [3:0]        cond;
    logic              flag_n, flag_z, flag_c, flag_v;
    logic              cond_pass, cond_ok;
    logic              eval, stage_free, push, pop, load, squash;
    logic              unused_cpsr;

    assign head   = mem[rd_ptr];
    assign cond   = head[DATA_W-1 -: 4];
    assign flag_n = cpsr[31];
    assign flag_z = cpsr[30];
    assign flag_c = cpsr[29];
    assign flag_v = cpsr[28];
    assign unused_cpsr = ^cpsr[27:0];

    always_comb begin
        cond_pass = 1'b0;
        case (cond)
            4'b0000: cond_pass = flag_z;
            4'b0001: cond_pass = !flag_z;
            4'b0010: cond_pass = flag_c;
            4'b0011: cond_pass = !flag_c;
            4'b0100: cond_pass = flag_n;
            4'b0101: cond_pass = !flag_n;
            4'b0110: cond_pass = flag_v;
            4'b0111: cond_pass = !flag_v;
            4'b1000: cond_pass = flag_c && !flag_z;
            4'b1001: cond_pass = !flag_c || flag_z;
            4'b1010: cond_pass = (flag_n == flag_v);
            4'b1011: cond_pass = (flag_n != flag_v);
            4'b1100: cond_pass = !flag_z && (flag_n == flag_v);
            4'b1101: cond_pass = flag_z || (flag_n != flag_v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    // A failing head is dropped regardless of backpressure; a passing one waits for the stage
    assign cond_ok    = cond_bypass || cond_pass;
    assign in_ready   = (count < FULL);
    assign stage_free = !out_valid || out_ready;
    assign eval       = (count != '0) && !flags_busy && !flush;
    assign load       = eval && cond_ok && stage_free;
    assign squash     = eval && !cond_ok;
    assign pop        = load || squash;
    assign push       = in_valid && in_ready && !flush;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            squash_count <= '0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= head;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (squash && squash_count != CNT_MAX) begin
                squash_count <= squash_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cond_issue_queue.sv
// tb/tb_cond_issue_queue.sv - scoreboard bench for cond_issue_queue with a queue-based reference model
module tb_cond_issue_queue;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = 4;
    localparam int SQMAX = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [31:0]   cpsr;
    logic          flags_busy;
    logic          flush;
    logic          cond_bypass;
    logic [CW-1:0] squash_count;

    cond_issue_queue #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .cpsr(cpsr), .flags_busy(flags_busy), .flush(flush),
        .cond_bypass(cond_bypass), .squash_count(squash_count)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference state: queued words, issue-register occupancy, squash tally, words awaiting handshake
    logic [DW-1:0] mq[$];
    logic          m_ov;
    int            m_sq;
    logic [DW-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic bit passes(input logic [31:0] w, input logic [31:0] f, input logic byp);
        bit n, z, c, v;
        n = f[31]; z = f[30]; c = f[29]; v = f[28];
        if (byp) return 1'b1;
        case (w[31:28])
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return c;
            4'd3:  return !c;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return c && !z;
            4'd9:  return !c || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Called at posedge+1: drives one cycle of inputs, advances the model, checks state after the edge
    task automatic cycle(input logic iv, input logic [31:0] d, input logic ordy, input logic busy,
                         input logic fl, input logic byp, input logic [31:0] cp);
        bit room;
        in_valid = iv; in_data = d; out_ready = ordy; flags_busy = busy;
        flush = fl; cond_bypass = byp; cpsr = cp;
        room = (mq.size() < DEPTH);
        if (fl) begin
            mq.delete();
            exp_q.delete();
            m_ov = 1'b0;
        end else begin
            bit free;
            free = !m_ov || ordy;
            if (m_ov && ordy) m_ov = 1'b0;
            if (mq.size() > 0 && !busy) begin
                if (!passes(mq[0], cp, byp)) begin
                    void'(mq.pop_front());
                    if (m_sq < SQMAX) m_sq++;
                end else if (free) begin
                    exp_q.push_back(mq.pop_front());
                    m_ov = 1'b1;
                end
            end
            if (iv && room) mq.push_back(d);
        end
        @(posedge clk);
        #1;
        check("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
        check("out_valid", 32'(out_valid), 32'(m_ov));
        check("squash_count", 32'(squash_count), 32'(m_sq));
    endtask

    task automatic idle(input int n, input logic [31:0] cp);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, cp);
    endtask

    // Monitor: just before each edge, a pending handshake must carry the oldest expected word
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (reset && out_valid && out_ready && !flush) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL issue_unexpected: got %0h, expected no issue", out_data);
                end else begin
                    check("issue_data", out_data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [31:0] r, rd, sq_before, held;
        reset = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        cpsr = '0; flags_busy = 1'b0; flush = 1'b0; cond_bypass = 1'b0;
        m_ov = 1'b0; m_sq = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(out_valid), 32'h0);
        check("reset_out_data", out_data, 32'h0);
        check("reset_squash", 32'(squash_count), 32'h0);
        reset = 1'b1;
        #1;
        check("reset_in_ready", 32'(in_ready), 32'h1);
        @(posedge clk);
        #1;

        // Pass path with its one-edge latency
        cycle(1'b1, 32'h0A00_0001, 1'b1, 1'b0, 1'b0, 1'b0, 32'h4000_0000);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h4000_0000);
        check("pass_latency", 32'(out_valid), 32'h1);
        check("pass_data", out_data, 32'h0A00_0001);
        idle(2, 32'h4000_0000);

        // LS fails with C=1,Z=0, then passes with Z=1
        cycle(1'b1, 32'h9000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h2000_0000);
        cycle(1'b1, 32'hE000_0002, 1'b1, 1'b0, 1'b0, 1'b0, 32'h2000_0000);
        idle(3, 32'h2000_0000);
        check("ls_squash", 32'(squash_count), 32'h1);
        cycle(1'b1, 32'h9000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h4000_0000);
        idle(3, 32'h4000_0000);
        check("ls_pass", 32'(squash_count), 32'h1);

        // NV squashed normally, issued under bypass
        cycle(1'b1, 32'hF000_0003, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        idle(2, 32'h0);
        check("nv_squash", 32'(squash_count), 32'h2);
        cycle(1'b1, 32'hF000_0003, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
        idle(2, 32'h0);
        check("nv_bypass", 32'(squash_count), 32'h2);

        // Fill FIFO plus issue register under backpressure, then drain
        for (int i = 0; i < DEPTH + 2; i++)
            cycle(1'b1, 32'hE000_0100 + 32'(i), 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("full_in_ready", 32'(in_ready), 32'h0);
        held = out_data;
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("full_data_stable", out_data, held);
        check("full_first_word", out_data, 32'hE000_0100);
        idle(DEPTH + 2, 32'h0);

        // Interlock: head held while flags busy, evaluated with the new flags
        sq_before = 32'(squash_count);
        cycle(1'b1, 32'h0A00_0010, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h4000_0000);
        check("interlock_issue", 32'(out_valid), 32'h1);
        check("interlock_no_squash", 32'(squash_count), sq_before);
        idle(2, 32'h0);

        // Flush with queued words and a pending issue
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 32'hE000_0200 + 32'(i), 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 32'hE000_02FF, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        check("flush_out_valid", 32'(out_valid), 32'h0);
        check("flush_in_ready", 32'(in_ready), 32'h1);
        idle(3, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r  = $urandom;
            rd = $urandom;
            cycle((r[3:0] < 11), rd, (r[7:4] < 11), (r[11:8] < 3), (r[19:12] < 8),
                  (r[23:20] < 2), $urandom);
        end
        idle(DEPTH + 3, 32'h0);

        // Asynchronous reset while an issue is pending
        cycle(1'b1, 32'hE000_0300, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 32'hE000_0301, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 32'h0000_0302, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("async_out_valid", 32'(out_valid), 32'h0);
        check("async_out_data", out_data, 32'h0);
        check("async_squash", 32'(squash_count), 32'h0);
        mq.delete(); exp_q.delete(); m_ov = 1'b0; m_sq = 0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("post_reset_in_ready", 32'(in_ready), 32'h1);
        @(posedge clk);
        #1;
        cycle(1'b1, 32'hE000_0400, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        idle(3, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
